sd_spi_target: RTL and testbench



---
 rtl/sd_spi_target.sv | 361 ++++++++++++++++++++++++++++++++++++
 tb/tb_sd_spi_target.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_target.sv
// SPI-mode SD card responder: decodes command frames, answers R1/R3/R7, serves CMD17/CMD24 blocks.
// Define SD_TGT_CRC_CHECK_EN to check the command CRC7 (mismatch -> R1 CRC error bit, command dropped).
module sd_spi_target #(
    parameter int unsigned BUSY_BYTES = 4,
    parameter int unsigned NCR_BYTES  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spi_sclk_i,
    input  logic        spi_cs_n_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        spi_miso_oe_o,
    output logic [31:0] blk_addr_o,
    output logic [8:0]  byte_idx_o,
    output logic        mem_rd_o,
    input  logic [7:0]  mem_rdata_i,
    output logic        mem_wr_o,
    output logic [7:0]  mem_wdata_o,
    output logic        card_ready_o,
    output logic        busy_o
);

    typedef enum logic [3:0] {
        S_CMD_RX,
        S_NCR,
        S_RESP,
        S_RD_GAP,
        S_RD_TOKEN,
        S_RD_DATA,
        S_RD_CRC,
        S_WR_TOKEN,
        S_WR_DATA,
        S_WR_CRC,
        S_WR_DRESP,
        S_WR_BUSY
    } state_t;

    state_t      r_state;
    state_t      r_after;
    logic [1:0]  r_sclk_s;
    logic        r_sclk_d;
    logic [1:0]  r_cs_s;
    logic [1:0]  r_mosi_s;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_rx_sr;
    logic [7:0]  r_tx_sr;
    logic [37:0] r_cmd;
    logic [2:0]  r_cmd_cnt;
    logic [7:0]  r_r1;
    logic [31:0] r_resp;
    logic        r_long;
    logic [8:0]  r_cnt;
    logic        r_idle;
    logic        r_app;
    logic        r_rd_pend;
    logic [7:0]  r_rd_buf;
    logic [15:0] r_crc16;
    logic        r_wr_inc;

    logic        w_cs_act;
    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic [7:0]  w_rx_byte;
    logic [5:0]  w_cmd_idx;
    logic [31:0] w_arg;
    logic        w_crc_err;
    logic [7:0]  w_r1;
    logic [31:0] w_tail;
    logic        w_long;
    state_t      w_after;

    assign w_cs_act    = ~r_cs_s[1];
    assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_d;
    assign w_rx_byte   = {r_rx_sr, r_mosi_s[1]};
    assign w_cmd_idx   = r_cmd[37:32];
    assign w_arg       = r_cmd[31:0];

    function automatic logic [15:0] f_crc16(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[15] ^ d[7-i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

`ifdef SD_TGT_CRC_CHECK_EN
    function automatic logic [6:0] f_crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int unsigned i = 0; i < 40; i++) begin
            fb = c[6] ^ d[39-i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // Start bits 01 are implied: only frames beginning with them are collected.
    assign w_crc_err = (f_crc7({2'b01, r_cmd}) != w_rx_byte[7:1]);
`else
    assign w_crc_err = 1'b0;
`endif

    always_comb begin
        w_r1    = {7'b0, r_idle};
        w_tail  = '1;
        w_long  = 1'b0;
        w_after = S_CMD_RX;
        if (w_crc_err) begin
            w_r1[3] = 1'b1;
        end else begin
            case (w_cmd_idx)
                6'd0:  w_r1 = 8'h01;
                6'd8: begin
                    w_long = 1'b1;
                    w_tail = {24'h000001, w_arg[7:0]};
                end
                6'd55: w_r1 = {7'b0, r_idle};
                6'd41: begin
                    if (r_app) w_r1 = 8'h00;
                    else       w_r1[2] = 1'b1;
                end
                6'd58: begin
                    w_long = 1'b1;
                    w_tail = 32'hC0FF8000;
                end
                6'd17, 6'd24: begin
                    if (r_idle) begin
                        w_r1[2] = 1'b1;
                    end else begin
                        w_r1    = 8'h00;
                        w_after = (w_cmd_idx == 6'd17) ? S_RD_GAP : S_WR_TOKEN;
                    end
                end
                default: w_r1[2] = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_CMD_RX;
            r_after       <= S_CMD_RX;
            r_sclk_s      <= '0;
            r_sclk_d      <= 1'b0;
            r_cs_s        <= '1;
            r_mosi_s      <= '1;
            r_bit_cnt     <= '0;
            r_rx_sr       <= '0;
            r_tx_sr       <= '1;
            r_cmd         <= '0;
            r_cmd_cnt     <= '0;
            r_r1          <= '1;
            r_resp        <= '1;
            r_long        <= 1'b0;
            r_cnt         <= '0;
            r_idle        <= 1'b1;
            r_app         <= 1'b0;
            r_rd_pend     <= 1'b0;
            r_rd_buf      <= '0;
            r_crc16       <= '0;
            r_wr_inc      <= 1'b0;
            spi_miso_o    <= 1'b1;
            spi_miso_oe_o <= 1'b0;
            blk_addr_o    <= '0;
            byte_idx_o    <= '0;
            mem_rd_o      <= 1'b0;
            mem_wr_o      <= 1'b0;
            mem_wdata_o   <= '0;
            card_ready_o  <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            r_sclk_s      <= {r_sclk_s[0], spi_sclk_i};
            r_sclk_d      <= r_sclk_s[1];
            r_cs_s        <= {r_cs_s[0], spi_cs_n_i};
            r_mosi_s      <= {r_mosi_s[0], spi_mosi_i};
            spi_miso_oe_o <= w_cs_act;
            mem_rd_o      <= 1'b0;
            mem_wr_o      <= 1'b0;
            r_rd_pend     <= mem_rd_o;
            r_wr_inc      <= 1'b0;
            if (r_rd_pend) r_rd_buf <= mem_rdata_i;
            // Write address advances the cycle after the strobe so the strobe carries its own index.
            if (r_wr_inc) byte_idx_o <= byte_idx_o + 9'd1;

            if (!w_cs_act) begin
                r_state    <= S_CMD_RX;
                r_bit_cnt  <= '0;
                r_cmd_cnt  <= '0;
                r_tx_sr    <= '1;
                spi_miso_o <= 1'b1;
                busy_o     <= 1'b0;
            end else begin
                if (w_sclk_fall) begin
                    spi_miso_o <= r_tx_sr[7];
                    r_tx_sr    <= {r_tx_sr[6:0], 1'b1};
                end
                if (w_sclk_rise) begin
                    r_rx_sr   <= w_rx_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        // Each branch decides the byte that occupies the next slot on MISO.
                        case (r_state)
                            S_CMD_RX: begin
                                r_tx_sr <= 8'hFF;
                                if (r_cmd_cnt == 3'd5) begin
                                    r_cmd_cnt <= '0;
                                    r_state   <= S_NCR;
                                    r_cnt     <= 9'(NCR_BYTES - 1);
                                    r_r1      <= w_r1;
                                    r_resp    <= w_tail;
                                    r_long    <= w_long;
                                    r_after   <= w_after;
                                    if (!w_crc_err) begin
                                        r_app <= (w_cmd_idx == 6'd55);
                                        case (w_cmd_idx)
                                            6'd0:  r_idle <= 1'b1;
                                            6'd41: begin
                                                if (r_app) begin
                                                    r_idle       <= 1'b0;
                                                    card_ready_o <= 1'b1;
                                                end
                                            end
                                            6'd17, 6'd24: begin
                                                if (!r_idle) begin
                                                    blk_addr_o <= w_arg;
                                                    byte_idx_o <= '0;
                                                end
                                            end
                                            default: ;
                                        endcase
                                    end
                                end else if (r_cmd_cnt != 3'd0 || w_rx_byte[7:6] == 2'b01) begin
                                    r_cmd     <= {r_cmd[29:0], w_rx_byte};
                                    r_cmd_cnt <= r_cmd_cnt + 3'd1;
                                end
                            end
                            S_NCR: begin
                                if (r_cnt == 9'd0) begin
                                    r_tx_sr <= r_r1;
                                    r_state <= S_RESP;
                                    r_cnt   <= r_long ? 9'd4 : 9'd0;
                                    busy_o  <= (r_after != S_CMD_RX);
                                end else begin
                                    r_tx_sr <= 8'hFF;
                                    r_cnt   <= r_cnt - 9'd1;
                                end
                            end
                            S_RESP: begin
                                if (r_cnt != 9'd0) begin
                                    r_tx_sr <= r_resp[31:24];
                                    r_resp  <= {r_resp[23:0], 8'hFF};
                                    r_cnt   <= r_cnt - 9'd1;
                                end else begin
                                    r_tx_sr <= 8'hFF;
                                    r_state <= r_after;
                                    r_cnt   <= '0;
                                end
                            end
                            S_RD_GAP: begin
                                r_tx_sr  <= 8'hFE;
                                r_state  <= S_RD_TOKEN;
                                mem_rd_o <= 1'b1;
                            end
                            S_RD_TOKEN: begin
                                r_tx_sr    <= r_rd_buf;
                                r_crc16    <= f_crc16(16'h0000, r_rd_buf);
                                byte_idx_o <= byte_idx_o + 9'd1;
                                mem_rd_o   <= 1'b1;
                                r_state    <= S_RD_DATA;
                                r_cnt      <= '0;
                            end
                            S_RD_DATA: begin
                                if (r_cnt == 9'd511) begin
                                    r_tx_sr    <= r_crc16[15:8];
                                    r_state    <= S_RD_CRC;
                                    byte_idx_o <= '0;
                                    r_cnt      <= '0;
                                end else begin
                                    r_tx_sr <= r_rd_buf;
                                    r_crc16 <= f_crc16(r_crc16, r_rd_buf);
                                    r_cnt   <= r_cnt + 9'd1;
                                    if (byte_idx_o != 9'd511) begin
                                        byte_idx_o <= byte_idx_o + 9'd1;
                                        mem_rd_o   <= 1'b1;
                                    end
                                end
                            end
                            S_RD_CRC: begin
                                if (r_cnt == 9'd0) begin
                                    r_tx_sr <= r_crc16[7:0];
                                    r_cnt   <= 9'd1;
                                end else begin
                                    r_tx_sr <= 8'hFF;
                                    r_state <= S_CMD_RX;
                                    busy_o  <= 1'b0;
                                end
                            end
                            S_WR_TOKEN: begin
                                r_tx_sr <= 8'hFF;
                                if (w_rx_byte == 8'hFE) begin
                                    r_state <= S_WR_DATA;
                                    r_cnt   <= '0;
                                end
                            end
                            S_WR_DATA: begin
                                r_tx_sr     <= 8'hFF;
                                mem_wr_o    <= 1'b1;
                                mem_wdata_o <= w_rx_byte;
                                r_wr_inc    <= 1'b1;
                                if (r_cnt == 9'd511) begin
                                    r_state <= S_WR_CRC;
                                    r_cnt   <= '0;
                                end else begin
                                    r_cnt <= r_cnt + 9'd1;
                                end
                            end
                            S_WR_CRC: begin
                                if (r_cnt == 9'd0) begin
                                    r_tx_sr <= 8'hFF;
                                    r_cnt   <= 9'd1;
                                end else begin
                                    r_tx_sr <= 8'h05;
                                    r_state <= S_WR_DRESP;
                                end
                            end
                            S_WR_DRESP: begin
                                if (BUSY_BYTES == 0) begin
                                    r_tx_sr <= 8'hFF;
                                    r_state <= S_CMD_RX;
                                    busy_o  <= 1'b0;
                                end else begin
                                    r_tx_sr <= 8'h00;
                                    r_state <= S_WR_BUSY;
                                    r_cnt   <= 9'(BUSY_BYTES - 1);
                                end
                            end
                            S_WR_BUSY: begin
                                if (r_cnt == 9'd0) begin
                                    r_tx_sr <= 8'hFF;
                                    r_state <= S_CMD_RX;
                                    busy_o  <= 1'b0;
                                end else begin
                                    r_tx_sr <= 8'h00;
                                    r_cnt   <= r_cnt - 9'd1;
                                end
                            end
                            default: r_state <= S_CMD_RX;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_target.sv
// Scoreboard bench for sd_spi_target: host SPI driver queues expected MISO bytes, a monitor checks them.
module tb_sd_spi_target;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b1;
    logic        miso;
    logic        miso_oe;
    logic [31:0] blk_addr;
    logic [8:0]  byte_idx;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic        card_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int rd_base;

    typedef struct {
        logic [7:0] val;
        string      tag;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] mon_sr = 8'h00;
    int         mon_bits = 0;

    sd_spi_target #(.BUSY_BYTES(4), .NCR_BYTES(1)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .spi_sclk_i   (sclk),
        .spi_cs_n_i   (cs_n),
        .spi_mosi_i   (mosi),
        .spi_miso_o   (miso),
        .spi_miso_oe_o(miso_oe),
        .blk_addr_o   (blk_addr),
        .byte_idx_o   (byte_idx),
        .mem_rd_o     (mem_rd),
        .mem_rdata_i  (mem_rdata),
        .mem_wr_o     (mem_wr),
        .mem_wdata_o  (mem_wdata),
        .card_ready_o (card_ready),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Backing store: byte k of any sector reads back as k[7:0], one cycle after the strobe.
    always @(posedge clk) if (mem_rd) mem_rdata <= byte_idx[7:0];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_rd) rd_cnt++;
        if (mem_wr) begin
            check("wr_data", 64'(mem_wdata), 64'h A5);
            check("wr_idx", 64'(byte_idx), 64'(wr_cnt));
            wr_cnt++;
        end
    end

    always @(posedge cs_n) mon_bits = 0;

    always @(posedge sclk) begin
        exp_t e;
        if (!cs_n) begin
            mon_sr = {mon_sr[6:0], miso};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %02h with nothing queued", mon_sr);
                end else begin
                    e = exp_q.pop_front();
                    check(e.tag, 64'(mon_sr), 64'(e.val));
                end
            end
        end
    end

    task automatic xfer(input logic [7:0] tx, input logic [7:0] ex, input string tag);
        exp_q.push_back('{val: ex, tag: tag});
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (3) @(negedge clk);
            sclk = 1'b1;
            repeat (3) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_on();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_off();
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    function automatic logic [7:0] crc7_byte(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        logic [6:0]  c;
        m = {2'b01, idx, arg};
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            if (c[6] != m[i]) c = {c[5:0], 1'b0} ^ 7'h09;
            else              c = {c[5:0], 1'b0};
        end
        return {c, 1'b1};
    endfunction

    function automatic logic [15:0] crc16_block();
        logic [15:0] c;
        c = 16'h0000;
        for (int k = 0; k < 512; k++) begin
            c = c ^ {k[7:0], 8'h00};
            for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    // Command frame plus the NCR filler byte; MISO idles at FF throughout.
    task automatic cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        xfer({2'b01, idx}, 8'hFF, "miso_cmd_idle");
        for (int i = 3; i >= 0; i--) xfer(arg[8*i +: 8], 8'hFF, "miso_cmd_idle");
        xfer(crc, 8'hFF, "miso_cmd_idle");
        xfer(8'hFF, 8'hFF, "ncr_fill");
    endtask

    task automatic acmd(input logic [5:0] idx, input logic [31:0] arg);
        cmd(idx, arg, crc7_byte(idx, arg));
    endtask

    initial begin
        logic [15:0] crc;
        crc = crc16_block();

        repeat (3) @(negedge clk);
        check("rst_miso", 64'(miso), 64'h1);
        check("rst_miso_oe", 64'(miso_oe), 64'h0);
        check("rst_blk_addr", 64'(blk_addr), 64'h0);
        check("rst_byte_idx", 64'(byte_idx), 64'h0);
        check("rst_mem_strobes", 64'({mem_rd, mem_wr}), 64'h0);
        check("rst_wdata", 64'(mem_wdata), 64'h0);
        check("rst_ready_busy", 64'({card_ready, busy}), 64'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        cs_on();
        check("miso_oe_active", 64'(miso_oe), 64'h1);
        cmd(6'd0, 32'h0, 8'h95);
        xfer(8'hFF, 8'h01, "cmd0_r1");
        check("ready_after_cmd0", 64'(card_ready), 64'h0);

`ifdef SD_TGT_CRC_CHECK_EN
        cmd(6'd0, 32'h0, 8'h00);
        xfer(8'hFF, 8'h09, "cmd0_badcrc_r1");
`else
        cmd(6'd0, 32'h0, 8'h00);
        xfer(8'hFF, 8'h01, "cmd0_badcrc_r1");
`endif
        cmd(6'd0, 32'h0, 8'h95);
        xfer(8'hFF, 8'h01, "cmd0_goodcrc_r1");

        acmd(6'd17, 32'h20);
        xfer(8'hFF, 8'h05, "cmd17_idle_r1");
        xfer(8'hFF, 8'hFF, "cmd17_idle_no_token");
        xfer(8'hFF, 8'hFF, "cmd17_idle_no_token");
        check("cmd17_idle_no_reads", 64'(rd_cnt), 64'h0);
        check("cmd17_idle_not_busy", 64'(busy), 64'h0);

        acmd(6'd8, 32'h000001AA);
        xfer(8'hFF, 8'h01, "cmd8_r1");
        xfer(8'hFF, 8'h00, "cmd8_b1");
        xfer(8'hFF, 8'h00, "cmd8_b2");
        xfer(8'hFF, 8'h01, "cmd8_b3");
        xfer(8'hFF, 8'hAA, "cmd8_b4");

        acmd(6'd55, 32'h0);
        xfer(8'hFF, 8'h01, "cmd55_r1");
        acmd(6'd41, 32'h40000000);
        xfer(8'hFF, 8'h00, "acmd41_r1");
        check("ready_after_acmd41", 64'(card_ready), 64'h1);

        acmd(6'd58, 32'h0);
        xfer(8'hFF, 8'h00, "cmd58_r1");
        xfer(8'hFF, 8'hC0, "cmd58_ocr3");
        xfer(8'hFF, 8'hFF, "cmd58_ocr2");
        xfer(8'hFF, 8'h80, "cmd58_ocr1");
        xfer(8'hFF, 8'h00, "cmd58_ocr0");

        acmd(6'd17, 32'h10);
        xfer(8'hFF, 8'h00, "rd_r1");
        check("rd_busy", 64'(busy), 64'h1);
        check("rd_blk_addr", 64'(blk_addr), 64'h10);
        xfer(8'hFF, 8'hFF, "rd_gap");
        xfer(8'hFF, 8'hFE, "rd_token");
        for (int k = 0; k < 512; k++) xfer(8'hFF, k[7:0], "rd_data");
        xfer(8'hFF, crc[15:8], "rd_crc_hi");
        xfer(8'hFF, crc[7:0], "rd_crc_lo");
        xfer(8'hFF, 8'hFF, "rd_tail_idle");
        check("rd_count", 64'(rd_cnt), 64'd512);
        check("rd_busy_fall", 64'(busy), 64'h0);
        check("rd_idx_wrap", 64'(byte_idx), 64'h0);

        acmd(6'd24, 32'h3);
        xfer(8'hFF, 8'h00, "wr_r1");
        check("wr_busy", 64'(busy), 64'h1);
        xfer(8'hFF, 8'hFF, "wr_token_wait");
        xfer(8'hFE, 8'hFF, "wr_token");
        for (int k = 0; k < 512; k++) xfer(8'hA5, 8'hFF, "wr_data_miso");
        xfer(8'hFF, 8'hFF, "wr_crc_miso");
        xfer(8'hFF, 8'hFF, "wr_crc_miso");
        xfer(8'hFF, 8'h05, "wr_dresp");
        for (int k = 0; k < 4; k++) xfer(8'hFF, 8'h00, "wr_busy_byte");
        xfer(8'hFF, 8'hFF, "wr_tail_idle");
        check("wr_count", 64'(wr_cnt), 64'd512);
        check("wr_busy_fall", 64'(busy), 64'h0);
        check("wr_blk_addr", 64'(blk_addr), 64'h3);
        check("wr_idx_wrap", 64'(byte_idx), 64'h0);

        acmd(6'd63, 32'h0);
        xfer(8'hFF, 8'h04, "cmd63_r1");

        rd_base = rd_cnt;
        acmd(6'd17, 32'h40);
        xfer(8'hFF, 8'h00, "abort_r1");
        xfer(8'hFF, 8'hFF, "abort_gap");
        xfer(8'hFF, 8'hFE, "abort_token");
        for (int k = 0; k < 100; k++) xfer(8'hFF, k[7:0], "abort_data");
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_miso_oe", 64'(miso_oe), 64'h0);
        check("abort_reads", 64'(rd_cnt - rd_base), 64'd102);
        check("abort_ready_kept", 64'(card_ready), 64'h1);
        repeat (50) @(negedge clk);
        check("abort_no_more_reads", 64'(rd_cnt - rd_base), 64'd102);

        cs_on();
        cmd(6'd0, 32'h0, 8'h95);
        xfer(8'hFF, 8'h01, "post_abort_cmd0_r1");
        cs_off();

        repeat (20) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
